// File: rtl/ti_quad_pkg.sv
// Shared defaults, FSM state encoding and coefficient storage types for the
// quadratic-form evaluation pipeline.
package ti_quad_pkg;

  localparam int unsigned DefaultInW  = 16;
  localparam int unsigned DefaultOutW = 8;

  typedef enum logic [1:0] {
    StConfig = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } state_e;

  // Row i holds the linear coefficient at bit i and in[i]&in[j] at bit j>i.
  typedef logic [DefaultInW-1:0] row_mask_t;
  typedef row_mask_t [DefaultInW-1:0] row_mat_t;
  typedef row_mat_t [DefaultOutW-1:0] coef_mat_t;

endpackage

// File: rtl/ti_quad_row_term.sv
// Stage-1 partial products for one output bit: p[i] = in[i] & parity(row[i] & in).
module ti_quad_row_term
  import ti_quad_pkg::*;
#(
  parameter int unsigned IN_W = DefaultInW
) (
  input  logic [IN_W-1:0][IN_W-1:0] rows_i,
  input  logic [IN_W-1:0]           in_data_i,
  output logic [IN_W-1:0]           p_o
);

  // Bits below the diagonal are always stored as zero, so the full-row parity
  // only covers j >= i.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      p_o[i] = in_data_i[i] & (^(rows_i[i] & in_data_i));
    end
  end

endmodule

// File: rtl/ti_quad_eval_pipe.sv
// Two-stage elastic evaluator of OUT_W quadratic Boolean forms over an IN_W-bit
// shared input, with a CONFIG/ACTIVE/DRAIN coefficient-loading FSM.
module ti_quad_eval_pipe
  import ti_quad_pkg::*;
#(
  parameter int unsigned IN_W  = DefaultInW,
  parameter int unsigned OUT_W = DefaultOutW,
  localparam int unsigned SelW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int unsigned RowW = (IN_W > 1) ? $clog2(IN_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [SelW-1:0]  cfg_sel,
  input  logic [RowW-1:0]  cfg_row,
  input  logic [IN_W-1:0]  cfg_data,
  input  logic             cfg_commit,
  input  logic             cfg_unlock,
  output logic             cfg_err,
  output logic [1:0]       state_o
);

  state_e state_q, state_d;

  logic [OUT_W-1:0][IN_W-1:0][IN_W-1:0] coef_q;

  logic                        s1_valid_q;
  logic [OUT_W-1:0][IN_W-1:0]  p_q, p_d;
  logic                        out_valid_q;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic                        cfg_err_q, cfg_err_d;

  logic            s2_load, s1_load, accept;
  logic            cfg_in_range, cfg_wr;
  logic [IN_W-1:0] wr_row;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = (state_q == StActive) && s1_load;
  assign accept   = in_valid && in_ready;

  assign cfg_in_range = (32'(cfg_sel) < OUT_W) && (32'(cfg_row) < IN_W);
  assign cfg_wr       = cfg_we && (state_q == StConfig) && cfg_in_range;
  assign cfg_err_d    = cfg_we && !cfg_wr;
  // Clear the ignored lower-triangle bits so each monomial has one home.
  assign wr_row       = cfg_data & ({IN_W{1'b1}} << cfg_row);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StConfig: if (cfg_commit) state_d = StActive;
      StActive: if (cfg_unlock) state_d = StDrain;
      StDrain:  if (!s1_valid_q && !out_valid_q) state_d = StConfig;
      default:  state_d = StConfig;
    endcase
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_bit
    ti_quad_row_term #(
      .IN_W(IN_W)
    ) u_row_term (
      .rows_i    (coef_q[k]),
      .in_data_i (in_data),
      .p_o       (p_d[k])
    );
  end

  always_comb begin
    out_data_d = '0;
    for (int k = 0; k < OUT_W; k++) begin
      out_data_d[k] = ^p_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StConfig;
      coef_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      if (cfg_wr) begin
        coef_q[cfg_sel][cfg_row] <= wr_row;
      end
    end
  end

  // Stage 1 latches the products so share mixing never sees raw input glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= accept;
        if (accept) p_q <= p_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ti_quad_eval_pipe.sv
// Directed and randomized checks of ti_quad_eval_pipe against hand-computed
// values and an independent monomial-list model.
module tb_ti_quad_eval_pipe;

  localparam int unsigned InW   = 16;
  localparam int unsigned OutW  = 6;
  localparam int unsigned NTerm = 39;
  localparam int unsigned NRnd  = 1000;

  logic            clk, rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [InW-1:0]  in_data, cfg_data;
  logic [OutW-1:0] out_data;
  logic            cfg_we, cfg_commit, cfg_unlock, cfg_err;
  logic [2:0]      cfg_sel;
  logic [3:0]      cfg_row;
  logic [1:0]      state_o;

  int n_total = 0;
  int n_bad   = 0;

  int             ti[NTerm];
  int             tj[NTerm];
  logic [InW-1:0] rowm[InW];
  logic [OutW-1:0] exp_q[$];

  ti_quad_eval_pipe #(
    .IN_W  (InW),
    .OUT_W (OutW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_row    (cfg_row),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_unlock (cfg_unlock),
    .cfg_err    (cfg_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [3:0] row,
                           input logic [InW-1:0] data, input logic want_err);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_row  = row;
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    check("cfg_err", 32'(cfg_err), 32'(want_err));
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("commit_state", 32'(state_o), 1);
  endtask

  task automatic unlock_to_config();
    cfg_unlock = 1'b1;
    tick();
    cfg_unlock = 1'b0;
    check("unlock_drain", 32'(state_o), 2);
    tick();
    check("unlock_config", 32'(state_o), 0);
  endtask

  // Single transaction through an empty pipe with out_ready high.
  task automatic send_one(input logic [InW-1:0] d, input logic [OutW-1:0] want);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check("send_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("lat_s1", 32'(out_valid), 0);
    tick();
    check("lat_s2", 32'(out_valid), 1);
    check("send_data", 32'(out_data), 32'(want));
    tick();
  endtask

  function automatic logic anf(input logic [InW-1:0] x);
    logic r;
    r = 1'b0;
    for (int t = 0; t < int'(NTerm); t++) r ^= x[ti[t]] & x[tj[t]];
    return r;
  endfunction

  initial begin
    logic            hold;
    logic [OutW-1:0] hold_data;
    logic [OutW-1:0] want;
    logic [InW-1:0]  garbage;
    bit              used[InW][InW];
    int              sent, got, cyc, cnt, i, j;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_row = '0; cfg_data = '0;
    cfg_commit = 1'b0; cfg_unlock = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state_o), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    rst = 1'b0;
    tick();

    // Linear term in[1] on bit 0.
    cfg_write(3'd0, 4'd1, 16'h0002, 1'b0);
    commit();
    send_one(16'h0002, 6'h01);
    send_one(16'h0000, 6'h00);

    // in0&in1 on bit 0, written in the same cycle as commit.
    unlock_to_config();
    cfg_write(3'd0, 4'd1, 16'h0000, 1'b0);
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_row = 4'd0; cfg_data = 16'h0002; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check("wc_err", 32'(cfg_err), 0);
    check("wc_state", 32'(state_o), 1);
    send_one(16'h0003, 6'h01);
    send_one(16'h0001, 6'h00);
    send_one(16'h0002, 6'h00);

    // Writes rejected in ACTIVE and for out-of-range select.
    cfg_write(3'd0, 4'd0, 16'hFFFF, 1'b1);
    tick();
    check("err_pulse_once", 32'(cfg_err), 0);
    send_one(16'h0003, 6'h01);
    send_one(16'h0001, 6'h00);
    unlock_to_config();
    cfg_write(3'd6, 4'd0, 16'hFFFF, 1'b1);
    tick();
    check("err_sel_once", 32'(cfg_err), 0);
    cfg_write(3'd7, 4'd0, 16'hFFFF, 1'b1);
    // in2&in3 on bit 1 with junk below the diagonal that must be dropped.
    cfg_write(3'd1, 4'd2, 16'h000B, 1'b0);
    commit();
    send_one(16'h0003, 6'h01);
    send_one(16'h000D, 6'h02);
    send_one(16'h000F, 6'h03);

    // Unlock with two results stalled in the pipe.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0003;
    tick();
    in_data = 16'h000C;
    #1;
    check("fill_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; cfg_unlock = 1'b1;
    tick();
    cfg_unlock = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("drain_state", 32'(state_o), 2);
      check("drain_in_ready", 32'(in_ready), 0);
      check("drain_hold_v", 32'(out_valid), 1);
      check("drain_hold_d", 32'(out_data), 32'h01);
      if (k == 1) check("drain_we_err", 32'(cfg_err), 1);
      cfg_we = (k == 0); cfg_sel = 3'd0; cfg_row = 4'd0; cfg_data = 16'hFFFF;
      tick();
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    #1;
    check("drain_a_v", 32'(out_valid), 1);
    check("drain_a_d", 32'(out_data), 32'h01);
    tick();
    check("drain_b_v", 32'(out_valid), 1);
    check("drain_b_d", 32'(out_data), 32'h02);
    tick();
    check("drain_empty_v", 32'(out_valid), 0);
    check("drain_empty_state", 32'(state_o), 2);
    tick();
    check("drain_done_state", 32'(state_o), 0);
    commit();
    send_one(16'h0001, 6'h00);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0003;
    tick();
    in_data = 16'h000C;
    tick();
    in_valid = 1'b0;
    check("full_v", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_v", 32'(out_valid), 0);
    check("mid_rst_state", 32'(state_o), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_v", 32'(out_valid), 0);
    commit();
    send_one(16'h0003, 6'h00);
    send_one(16'h000C, 6'h00);
    send_one(16'hFFFF, 6'h00);

    // Random 39-monomial form on bit 0 under random backpressure.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < int'(InW); a++) begin
      rowm[a] = '0;
      for (int b = 0; b < int'(InW); b++) used[a][b] = 1'b0;
    end
    cnt = 0;
    while (cnt < int'(NTerm)) begin
      i = int'($urandom_range(0, InW - 1));
      j = int'($urandom_range(i, InW - 1));
      if (!used[i][j]) begin
        used[i][j] = 1'b1;
        ti[cnt] = i;
        tj[cnt] = j;
        rowm[i][j] = 1'b1;
        cnt++;
      end
    end
    for (int r = 0; r < int'(InW); r++) begin
      garbage = InW'($urandom()) & ((16'h0001 << r) - 16'h0001);
      cfg_write(3'd0, 4'(r), rowm[r] | garbage, 1'b0);
    end
    commit();

    sent = 0; got = 0; cyc = 0; hold = 1'b0; hold_data = '0;
    while (got < int'(NRnd) && cyc < 20000) begin
      in_valid  = (sent < int'(NRnd)) && ($urandom_range(0, 3) != 0);
      in_data   = InW'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (hold) begin
        check("rnd_hold_v", 32'(out_valid), 1);
        check("rnd_hold_d", 32'(out_data), 32'(hold_data));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(OutW'(anf(in_data)));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra", 1, 0);
        end else begin
          want = exp_q.pop_front();
          check("rnd_data", 32'(out_data), 32'(want));
        end
        got++;
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_count", 32'(got), NRnd);
    check("rnd_left", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ti_quad_eval_pipe.md
TI_QUAD_EVAL_PIPE -- requirements
Module: ti_quad_eval_pipe

Interface
REQ-001 Parameter IN_W, default 16, number of input share bits.
REQ-002 Parameter OUT_W, default 8, number of output component bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  IN_W  shared input vector.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  OUT_W  evaluated component bits.
REQ-011 cfg_we  input  1  coefficient row write strobe.
REQ-012 cfg_sel  input  clog2(OUT_W)  target output bit.
REQ-013 cfg_row  input  clog2(IN_W)  target row i.
REQ-014 cfg_data  input  IN_W  row mask; bit i = linear coefficient of in[i]; bit j>i = coefficient of in[i]&in[j]; bits j<i ignored and stored as 0.
REQ-015 cfg_commit  input  1  leave CONFIG, enable evaluation.
REQ-016 cfg_unlock  input  1  request return to CONFIG.
REQ-017 cfg_err  output  1  one-cycle pulse: rejected write or out-of-range cfg_sel/cfg_row.
REQ-018 state_o  output  2  current FSM state encoding.

Function
REQ-019 Per output bit k: out_data[k] = XOR over i<=j of M[k][i][j]&in[i]&in[j], no constant term.
REQ-020 Stage 1 registers, per k and row i: p[k][i] = in[i] & XOR over j>=i of (M[k][i][j]&in[j]); glitch barrier between share mixing.
REQ-021 Stage 2 registers out_data[k] = XOR over i of p[k][i].
REQ-022 Latency exactly 2 cycles from accepted input to out_valid when out_ready held high; throughput one result per cycle.
REQ-023 Elastic pipeline: stage 2 loads when !out_valid or out_ready; stage 1 loads when stage 1 empty or moving; in_ready = (state==ACTIVE) and stage 1 can load.
REQ-024 out_data and out_valid hold stable while out_valid && !out_ready; no result dropped or duplicated.
REQ-025 FSM states: CONFIG (0), ACTIVE (1), DRAIN (2).
REQ-026 CONFIG: cfg_we writes row; in_ready=0; cfg_commit -> ACTIVE next cycle; cfg_we and cfg_commit same cycle: write applied, then transition.
REQ-027 ACTIVE: cfg_unlock -> DRAIN; cfg_we ignored, cfg_err pulses.
REQ-028 DRAIN: in_ready=0; pending results delivered under normal handshake; -> CONFIG in cycle after both stages empty; cfg_we rejected with cfg_err.
REQ-029 Out-of-range cfg_sel (>=OUT_W) or cfg_row (>=IN_W) in CONFIG: no write, cfg_err pulse.
REQ-030 Coefficients unchanged outside CONFIG; in-flight data always evaluated with committed matrix.

Reset
REQ-031 rst: all M cleared to 0, state CONFIG, both stage valids 0, out_data 0, out_valid 0, in_ready 0, cfg_err 0.
REQ-032 rst mid-operation discards in-flight results; no out_valid in the cycle after rst.

Structure
REQ-033 Package ti_quad_pkg holds IN_W/OUT_W defaults, state enum, row-mask and matrix typedefs.
REQ-034 One sub-module ti_quad_row_term computes stage-1 vector p[k][*] for a single output bit; instantiated OUT_W times.
REQ-035 RTL 120-400 lines; no latches, no combinational path from in_data to out_data.

Verification
REQ-036 Load k=0 row1 = 0x0002, commit; in_data=0x0002 -> out_data[0]=1 two cycles later; in_data=0x0000 -> 0.
REQ-037 Load k=0 row0 = 0x0002 (in0&in1); inputs 0x0003 -> 1, 0x0001 -> 0, 0x0002 -> 0.
REQ-038 Random 39-term ANF in bit 0, 1000 random inputs, random out_ready -> matches golden ANF model, order preserved, no loss.
REQ-039 cfg_unlock with 2 results in flight, out_ready=0 for 5 cycles -> state DRAIN, both results delivered after release, then CONFIG.
REQ-040 cfg_we in ACTIVE, cfg_sel=OUT_W in CONFIG -> cfg_err pulses, matrix unchanged.
REQ-041 rst asserted with stage 1 and 2 full -> next cycle out_valid=0, state CONFIG, all outputs 0 after recommit.
